// File: rtl/switch_merger.sv
// Two-input merger: per-input FIFOs, round-robin arbiter, registered output.
// Define SWITCH_MERGER_DROP_CNT_EN to add saturating per-side drop counters.
module switch_merger #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  vld_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  out_vld,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_src,
  input  logic                  out_rdy,
  output logic                  drop_a,
  output logic                  drop_b
`ifdef SWITCH_MERGER_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt_a,
  output logic [7:0]            drop_cnt_b
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [PW:0] ONE = 1;

  logic [WW-1:0] mem_a [FIFO_DEPTH];
  logic [WW-1:0] mem_b [FIFO_DEPTH];
  logic [PW:0]   wp_a, rp_a, wp_b, rp_b;
  logic          full_a, full_b, empty_a, empty_b;
  logic          wr_a, wr_b, pop_a, pop_b;
  logic          load, last_grant;

  // extra wrap bit distinguishes full from empty
  assign full_a  = (wp_a[PW] != rp_a[PW]) &&
                   (wp_a[PW-1:0] == rp_a[PW-1:0]);
  assign full_b  = (wp_b[PW] != rp_b[PW]) &&
                   (wp_b[PW-1:0] == rp_b[PW-1:0]);
  assign empty_a = (wp_a == rp_a);
  assign empty_b = (wp_b == rp_b);
  assign wr_a    = vld_a && !full_a;
  assign wr_b    = vld_b && !full_b;
  assign load    = !out_vld || out_rdy;

  always_comb begin
    pop_a = 1'b0;
    pop_b = 1'b0;
    if (load) begin
      unique case (1'b1)
        (!empty_a && !empty_b): begin
          pop_a = last_grant;
          pop_b = !last_grant;
        end
        (!empty_a && empty_b): pop_a = 1'b1;
        (empty_a && !empty_b): pop_b = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_a) mem_a[wp_a[PW-1:0]] <= {addr_a, data_a};
    if (wr_b) mem_b[wp_b[PW-1:0]] <= {addr_b, data_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_a <= '0;
      rp_a <= '0;
      wp_b <= '0;
      rp_b <= '0;
    end else begin
      if (wr_a)  wp_a <= wp_a + ONE;
      if (pop_a) rp_a <= rp_a + ONE;
      if (wr_b)  wp_b <= wp_b + ONE;
      if (pop_b) rp_b <= rp_b + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld    <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
    end else if (load) begin
      out_vld <= pop_a || pop_b;
      if (pop_a) begin
        {out_addr, out_data} <= mem_a[rp_a[PW-1:0]];
        out_src    <= 1'b0;
        last_grant <= 1'b0;
      end else if (pop_b) begin
        {out_addr, out_data} <= mem_b[rp_b[PW-1:0]];
        out_src    <= 1'b1;
        last_grant <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_a <= 1'b0;
      drop_b <= 1'b0;
    end else begin
      drop_a <= vld_a && full_a;
      drop_b <= vld_b && full_b;
    end
  end

`ifdef SWITCH_MERGER_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_a <= '0;
      drop_cnt_b <= '0;
    end else begin
      if (vld_a && full_a && drop_cnt_a != 8'hFF)
        drop_cnt_a <= drop_cnt_a + 8'd1;
      if (vld_b && full_b && drop_cnt_b != 8'hFF)
        drop_cnt_b <= drop_cnt_b + 8'd1;
    end
  end
`endif

endmodule

// File: doc/switch_merger.md
SWITCH_MERGER -- requirements
Module: switch_merger

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, sets the width of each address field.
REQ-002 Parameter DATA_WIDTH, default 16, sets the width of each data field.
REQ-003 Parameter FIFO_DEPTH, default 4, sets the entries per input FIFO; it shall be a power of two and at least 2.
REQ-004 The block shall use one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single clock, rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Ports vld_a, addr_a, data_a, input, 1/ADDR_WIDTH/DATA_WIDTH bits: port-A word offer, with no backpressure.
REQ-008 Ports vld_b, addr_b, data_b, input, 1/ADDR_WIDTH/DATA_WIDTH bits: port-B word offer, with no backpressure.
REQ-009 Ports out_vld, out_addr, out_data, output, 1/ADDR_WIDTH/DATA_WIDTH bits: merged output word.
REQ-010 Port out_src, output, 1 bit: source of the current output word (0 = A, 1 = B).
REQ-011 Port out_rdy, input, 1 bit: downstream accepts the output word.
REQ-012 Ports drop_a, drop_b, output, 1 bit each: one-cycle pulse when an offered word is discarded.

Function
REQ-013 The block shall hold one FIFO per input, storing {addr,data} in arrival order.
REQ-014 At a rising edge with vld_x=1, the word shall be written iff FIFO_x is not full at the start of the cycle. There is no write-through when a pop occurs in the same cycle.
REQ-015 When vld_x=1 and FIFO_x is full, the word shall be discarded and drop_x shall be 1 for exactly the next cycle.
REQ-016 Output register load condition: load enable = (!out_vld || out_rdy).
REQ-017 When load is enabled and at least one FIFO is non-empty, the arbiter shall pop exactly one FIFO into out_addr/out_data/out_src and set out_vld=1.
REQ-018 When load is enabled and both FIFOs are empty, out_vld shall become 0.
REQ-019 Arbitration shall be round-robin via a last_grant register:
- When both FIFOs are non-empty, grant the side != last_grant.
- When one FIFO is non-empty, grant that side.
- last_grant updates only on a pop.
REQ-020 While out_vld=1 and out_rdy=0, out_vld/out_addr/out_data/out_src shall hold stable and no pop shall occur.
REQ-021 Latency: a word sampled at edge k into an empty block with out_vld=0 shall appear with out_vld=1 after edge k+1.
REQ-022 Throughput: with out_rdy held at 1, one word per cycle shall be delivered while any FIFO is non-empty.
REQ-023 Simultaneous vld_a and vld_b shall both be accepted, subject to REQ-014.
REQ-024 FIFO pointers shall wrap modulo FIFO_DEPTH. Full/empty shall be derived from pointers with one extra wrap bit, so all FIFO_DEPTH entries are usable.
REQ-025 Words from the same input shall leave in arrival order, with no loss except per REQ-015.

Reset
REQ-026 When rst=1 at a rising edge, the block shall clear:
- both FIFOs (pointers to 0), contents don't-care;
- out_vld=0, out_addr=0, out_data=0, out_src=0;
- drop_a=drop_b=0;
- last_grant=1, so A wins the first tie.
REQ-027 Reset shall take precedence over all other activity; offers during reset shall be ignored without drop pulses.
REQ-028 Reset mid-transfer shall discard all buffered and held words.

Configuration
REQ-029 Macro SWITCH_MERGER_DROP_CNT_EN, when defined, shall add two outputs, drop_cnt_a and drop_cnt_b, each 8 bits.
REQ-030 Each drop counter shall increment on every discard on its side, saturate at 255, and reset to 0.
REQ-031 Without SWITCH_MERGER_DROP_CNT_EN, the counter ports and logic shall be absent; all other behaviour shall be identical.

Verification
REQ-032 Single word: vld_a=1, addr_a=8'h10, data_a=16'hBEEF for one cycle, out_rdy=1 -> after 2 edges out_vld=1, out_addr=8'h10, out_data=16'hBEEF, out_src=0, for one cycle.
REQ-033 Tie: A=(8'h01,16'h0001) and B=(8'h41,16'h0002) in the same cycle after reset -> A word output first, B word the next cycle.
REQ-034 Backpressure: out_rdy=0 while 4 A words are offered -> output holds the first word. After 5 total offers (DEPTH=4 plus 1 in the output register), the 6th offer produces a drop_a pulse. Releasing out_rdy -> 5 words out in order.
REQ-035 Fairness: both inputs streaming every cycle, out_rdy=1 -> out_src alternates 0,1,0,1. With the macro defined, drop counters rise on both sides and saturate at 255 after 255+ drops.
REQ-036 Reset mid-operation: both FIFOs full, rst=1 for one edge -> out_vld=0 next cycle, no drop pulses, and the next word in has latency 2.
